// File: rtl/serial_subtractor.sv
// Purpose : bit-serial WIDTH-bit subtractor, d = a - b - bw (mod 2^WIDTH), LSB first.
// Latency : WIDTH+1 cycles from accepted start to done_out; one result per WIDTH+2 cycles.
// Backpressure: none; start_in is only sampled in IDLE and ignored while busy or done.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start_in               request, sampled only when idle
//   a_in, b_in, bw_in      minuend, subtrahend, borrow-in (captured on accepted start)
//   d_out, bw_out          registered difference and borrow-out, held until next done
//   busy_out               high while bits are being processed
//   done_out               one-cycle pulse marking d_out/bw_out valid
//   ovf_out                two's-complement overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN (adds ovf_out).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bw_in,
  output logic [WIDTH-1:0] d_out,
  output logic             bw_out,
  output logic             busy_out,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf_out,
`endif
  output logic             done_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bwo_q, bwo_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-subtractor cell working on the current LSBs.
  logic bit_a, bit_b, diff_bit, borrow_bit;
  assign bit_a      = a_q[0];
  assign bit_b      = b_q[0];
  assign diff_bit   = bit_a ^ bit_b ^ br_q;
  assign borrow_bit = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dout_d  = dout_q;
    bwo_d   = bwo_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          br_d    = bw_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Difference bits enter at the MSB so that after WIDTH shifts bit 0 lands at res[0].
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = borrow_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          dout_d  = {diff_bit, res_q[WIDTH-1:1]};
          bwo_d   = borrow_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the final bit br_q is the borrow into the MSB, borrow_bit the borrow out.
          ovf_d   = br_q ^ borrow_bit;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      bwo_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      bwo_q   <= bwo_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign d_out    = dout_q;
  assign bw_out   = bwo_q;
  assign busy_out = (state_q == SHIFT);
  assign done_out = (state_q == DONE);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule
